// File: rtl/div_64_by_32_seq.sv
// Sequential radix-2 restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor.
// Optional divide-by-zero flag port output_dbz when DIV_DBZ_FLAG_EN is defined.
module div_64_by_32_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] input_a_tdata,
    input  logic               input_a_tvalid,
    output logic               input_a_tready,
    input  logic [WIDTH-1:0]   input_b_tdata,
    input  logic               input_b_tvalid,
    output logic               input_b_tready,
    output logic [2*WIDTH-1:0] output_q_tdata,
    output logic [WIDTH-1:0]   output_r_tdata,
    output logic               output_tvalid,
    input  logic               output_tready
`ifdef DIV_DBZ_FLAG_EN
   ,output logic               output_dbz
`endif
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   d_q, d_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   oq_q, oq_d;
    logic [WIDTH-1:0] or_q, or_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             ge;

`ifdef DIV_DBZ_FLAG_EN
    logic dbz_q, dbz_d;
`endif

    // Remainder stays below V, so the subtraction result fits WIDTH bits.
    assign trial = {rem_q, d_q[DW-1]};
    assign ge    = trial >= {1'b0, v_q};
    assign diff  = trial[WIDTH-1:0] - v_q;

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        quo_d   = quo_q;
        v_d     = v_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        oq_d    = oq_q;
        or_d    = or_q;
`ifdef DIV_DBZ_FLAG_EN
        dbz_d   = dbz_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (input_a_tvalid && input_b_tvalid) begin
                    d_d   = input_a_tdata;
                    v_d   = input_b_tdata;
                    rem_d = '0;
                    quo_d = '0;
                    cnt_d = '0;
                    if (input_b_tdata != '0) begin
                        state_d = CALC;
                    end else begin
                        state_d = DONE;
                        oq_d    = '1;
                        or_d    = input_a_tdata[WIDTH-1:0];
`ifdef DIV_DBZ_FLAG_EN
                        dbz_d   = 1'b1;
`endif
                    end
                end
            end
            CALC: begin
                d_d   = d_q << 1;
                rem_d = ge ? diff : trial[WIDTH-1:0];
                quo_d = {quo_q[DW-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    oq_d    = quo_d;
                    or_d    = rem_d;
`ifdef DIV_DBZ_FLAG_EN
                    dbz_d   = 1'b0;
`endif
                end
            end
            DONE: begin
                if (output_tready) begin
                    state_d = IDLE;
`ifdef DIV_DBZ_FLAG_EN
                    dbz_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            quo_q   <= '0;
            v_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            oq_q    <= '0;
            or_q    <= '0;
`ifdef DIV_DBZ_FLAG_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            v_q     <= v_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            oq_q    <= oq_d;
            or_q    <= or_d;
`ifdef DIV_DBZ_FLAG_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    // Inputs are not offered while reset is held.
    assign input_a_tready = (state_q == IDLE) & rst;
    assign input_b_tready = input_a_tready;
    assign output_tvalid  = (state_q == DONE);
    assign output_q_tdata = oq_q;
    assign output_r_tdata = or_q;
`ifdef DIV_DBZ_FLAG_EN
    assign output_dbz     = dbz_q;
`endif

endmodule

// File: tb/tb_div_64_by_32_seq.sv
// Directed and constructed-vector bench for div_64_by_32_seq.
// Expected quotients/remainders are hand-computed or built as a*b+r.
module tb_div_64_by_32_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [2*W-1:0] a_data = '0;
    logic           a_valid = 1'b0;
    logic           a_ready;
    logic [W-1:0]   b_data = '0;
    logic           b_valid = 1'b0;
    logic           b_ready;
    logic [2*W-1:0] q_data;
    logic [W-1:0]   r_data;
    logic           o_valid;
    logic           o_ready = 1'b1;
`ifdef DIV_DBZ_FLAG_EN
    logic           dbz;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_64_by_32_seq #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .input_a_tdata  (a_data),
        .input_a_tvalid (a_valid),
        .input_a_tready (a_ready),
        .input_b_tdata  (b_data),
        .input_b_tvalid (b_valid),
        .input_b_tready (b_ready),
        .output_q_tdata (q_data),
        .output_r_tdata (r_data),
        .output_tvalid  (o_valid),
        .output_tready  (o_ready)
`ifdef DIV_DBZ_FLAG_EN
       ,.output_dbz     (dbz)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; return edges from accept (inclusive) to tvalid.
    task automatic start_op(input logic [63:0] a, input logic [31:0] b,
                            output int lat);
        int k;
        k = 0;
        while (!a_ready && k < 200) begin
            tick();
            k++;
        end
        a_data  = a;
        b_data  = b;
        a_valid = 1'b1;
        b_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = '1;
        b_data  = '1;
        lat = 1;
        while (!o_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] a,
                          input logic [31:0] b, input logic [63:0] eq,
                          input logic [31:0] er, input int elat,
                          input bit chk_lat);
        int lat;
        start_op(a, b, lat);
        if (chk_lat) check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_valid"}, 64'(o_valid), 64'd1);
        check({tag, "_q"}, q_data, eq);
        check({tag, "_r"}, 64'(r_data), 64'(er));
        tick();
        check({tag, "_drop"}, 64'(o_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] held_q;
        logic [31:0] held_r;
        logic [31:0] ra, rb, rr;
        int lat;

        #2;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_q", q_data, 64'd0);
        check("rst_r", 64'(r_data), 64'd0);
        #20 rst = 1'b1;
        tick();
        check("rst_ready_a", 64'(a_ready), 64'd1);
        check("rst_ready_b", 64'(b_ready), 64'd1);

        run_op("basic", 64'd1000, 32'd7, 64'd142, 32'd6, 65, 1'b1);
        run_op("max", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF,
               64'h0000_0001_0000_0001, 32'd0, 65, 1'b1);
        run_op("dbz", 64'h0000_0012_3456_7890, 32'd0,
               64'hFFFF_FFFF_FFFF_FFFF, 32'h3456_7890, 1, 1'b1);
        run_op("one", 64'h8000_0000_0000_0001, 32'd1,
               64'h8000_0000_0000_0001, 32'd0, 65, 1'b0);
        run_op("small", 64'd5, 32'd9, 64'd0, 32'd5, 65, 1'b0);

`ifdef DIV_DBZ_FLAG_EN
        o_ready = 1'b0;
        start_op(64'd77, 32'd0, lat);
        check("dbz_flag", 64'(dbz), 64'd1);
        o_ready = 1'b1;
        tick();
        check("dbz_clr", 64'(dbz), 64'd0);
        run_op("flag_norm", 64'd77, 32'd7, 64'd11, 32'd0, 65, 1'b0);
        check("dbz_norm", 64'(dbz), 64'd0);
`endif

        // Backpressure: result held for 20 cycles.
        o_ready = 1'b0;
        start_op(64'd123456789, 32'd1000, lat);
        check("bp_lat", 64'(lat), 64'd65);
        held_q = q_data;
        held_r = r_data;
        check("bp_q", held_q, 64'd123456);
        check("bp_r", 64'(held_r), 64'd789);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_hold_v", 64'(o_valid), 64'd1);
            check("bp_hold_q", q_data, 64'd123456);
            check("bp_hold_r", 64'(r_data), 64'd789);
            check("bp_ready", 64'({a_ready, b_ready}), 64'd0);
        end
        o_ready = 1'b1;
        tick();
        check("bp_hs_v", 64'(o_valid), 64'd0);
        check("bp_hs_rdy", 64'(a_ready), 64'd1);
        check("bp_keep_q", q_data, 64'd123456);

        // A lone valid must not start anything.
        a_data  = 64'd50;
        a_valid = 1'b1;
        for (int i = 0; i < 70; i++) tick();
        check("lone_a_v", 64'(o_valid), 64'd0);
        check("lone_a_rdy", 64'(a_ready), 64'd1);
        a_valid = 1'b0;
        b_data  = 32'd3;
        b_valid = 1'b1;
        for (int i = 0; i < 70; i++) tick();
        check("lone_b_v", 64'(o_valid), 64'd0);
        b_valid = 1'b0;

        // Asynchronous reset in the middle of a calculation.
        a_data  = 64'hDEAD_BEEF_CAFE_BABE;
        b_data  = 32'h12345;
        a_valid = 1'b1;
        b_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        #2 rst = 1'b0;
        #1;
        check("arst_v", 64'(o_valid), 64'd0);
        check("arst_q", q_data, 64'd0);
        check("arst_r", 64'(r_data), 64'd0);
        check("arst_rdy", 64'(a_ready), 64'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 70; i++) tick();
        check("arst_stale", 64'(o_valid), 64'd0);
        run_op("post_rst", 64'd100, 32'd9, 64'd11, 32'd1, 65, 1'b1);

        // Constructed round trips: dividend = a*b + r, r < b.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = rb >> (i % 31);
            if (rb == 0) rb = 32'd1;
            rr = $urandom % rb;
            run_op($sformatf("rt%0d", i), 64'(ra) * 64'(rb) + 64'(rr),
                   rb, 64'(ra), rr, 65, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_64_by_32_seq.md
Name: div_64_by_32_seq

Overview:
- Sequential radix-2 restoring divider; the inverse of the team's 32x32 Karatsuba multiplier.
- Takes a 2*WIDTH-bit dividend (typically a product from the multiplier) and a WIDTH-bit divisor. Returns a 2*WIDTH-bit quotient and a WIDTH-bit remainder.
- Remainder output is the modular-reduction step of the ElGamal datapath. Same valid/ready stream style as the multiplier.

Parameters:
WIDTH, 32, divisor/remainder width; dividend and quotient are 2*WIDTH bits

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
input_a_tdata  input  2*WIDTH  dividend
input_a_tvalid  input  1  dividend valid
input_a_tready  output  1  dividend accepted when high with input_a_tvalid and input_b_tvalid
input_b_tdata  input  WIDTH  divisor
input_b_tvalid  input  1  divisor valid
input_b_tready  output  1  divisor ready; always equal to input_a_tready
output_q_tdata  output  2*WIDTH  quotient
output_r_tdata  output  WIDTH  remainder
output_tvalid  output  1  quotient/remainder valid
output_tready  input  1  downstream ready

Behaviour:
- Reset (rst=0, any time, asynchronous): state=IDLE; output_tvalid=0; output_q_tdata=0; output_r_tdata=0; input_*_tready=1 once rst=1.
- Reset mid-CALC or mid-DONE: the operation is abandoned and no output is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - input_a_tready = input_b_tready = 1.
  - Accept only on a joint handshake: input_a_tvalid & input_b_tvalid on a rising edge. A single valid is never consumed.
  - On accept: latch dividend into shift register D and divisor into V; clear partial remainder R (WIDTH+1 bits) and quotient Q; counter=0.
  - If divisor != 0, go to CALC. If divisor == 0, go to DONE.
- CALC: both treadys = 0. One iteration per clock, 2*WIDTH iterations (counter 0..2*WIDTH-1). Each iteration:
  - T = {R[WIDTH-1:0], D[MSB]}; D <<= 1.
  - If T >= {1'b0,V}: R = T - V and shift 1 into Q LSB. Otherwise R = T and shift 0 into Q LSB.
  - After iteration 2*WIDTH-1, go to DONE and load output_q_tdata=Q and output_r_tdata=R[WIDTH-1:0].
- Latency: output_tvalid rises exactly 2*WIDTH+1 rising edges after the accept edge (65 for WIDTH=32). For divide-by-zero it rises 1 edge after accept.
- DONE:
  - output_tvalid=1; both treadys = 0.
  - Output data are held stable while output_tvalid=1 and output_tready=0; no timeout.
  - On output_tvalid & output_tready: output_tvalid=0, go to IDLE. Output data registers keep their last value.
  - A new accept is possible no earlier than the edge after the output handshake. No overlap of operations.
- Divide by zero: quotient = all ones (2*WIDTH bits); remainder = input_a_tdata[WIDTH-1:0].
- Arithmetic invariant for divisor != 0: dividend = Q*V + R, with R < V.
- Input changes during CALC/DONE are ignored; latched copies are used.

Optional Feature:
- Macro: DIV_DBZ_FLAG_EN.
- Defined: adds output port output_dbz (1 bit).
  - Set together with output_tvalid when the accepted divisor was 0; cleared otherwise.
  - Held with the data; reset value 0; cleared on output handshake.
- Not defined: port absent. Divide-by-zero results are as above with no flag.

Test Plan:
- Basic: dividend=1000, divisor=7, output_tready=1 -> quotient=142, remainder=6; output_tvalid first high 65 edges after accept, for exactly 1 cycle.
- Max operands: dividend=0xFFFFFFFFFFFFFFFF, divisor=0xFFFFFFFF -> quotient=0x0000000100000001, remainder=0.
- Divide by zero: dividend=0x0000001234567890, divisor=0 -> quotient=0xFFFFFFFFFFFFFFFF, remainder=0x34567890, output_tvalid 1 edge after accept; output_dbz=1 when DIV_DBZ_FLAG_EN defined.
- Backpressure and joint handshake:
  - Hold output_tready=0 for 20 cycles after output_tvalid -> data stable, input treadys stay 0.
  - Raise output_tready -> handshake, then IDLE.
  - Assert only input_a_tvalid -> nothing accepted.
- Reset mid-operation: assert rst=0 at iteration 30 of dividend=0xDEADBEEFCAFEBABE, divisor=0x12345 -> output_tvalid=0 and outputs 0 immediately (asynchronous).
  - After release, run 100/9 -> quotient=11, remainder=1, no stale result.
- Back-to-back round trip: 200 random pairs where dividend = a*b + r with r < b, b != 0 -> quotient=a, remainder=r for every pair, in order.
